// File: rtl/fsm_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_resp_pkg
// Description : Shared types, constants and the MISR step function for the
//               controller response compactor.
// Revision    : 1.0  initial release
// ============================================================================
package fsm_resp_pkg;

    localparam int RESP_W = 22;

    // x^22 + x^21 + 1 : MSB feeds back into bits 21 and 0
    localparam logic [RESP_W-1:0] DEFAULT_POLY = 22'h200001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [RESP_W-1:0] misr_next(
        input logic [RESP_W-1:0] sig,
        input logic [RESP_W-1:0] y,
        input logic [RESP_W-1:0] poly
    );
        logic [RESP_W-1:0] shifted;
        shifted = {sig[RESP_W-2:0], 1'b0} ^ (sig[RESP_W-1] ? poly : '0);
        return shifted ^ y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_resp_misr_core.sv
`default_nettype none
// ============================================================================
// Module      : misr_core
// Description : WIDTH-bit multiple-input signature register with synchronous
//               seed load and absorb enable.
// Revision    : 1.0  initial release
// ============================================================================
module misr_core
    import fsm_resp_pkg::*;
#(
    parameter int               WIDTH = RESP_W,
    parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_sig
);

    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_next;

    generate
        if (WIDTH == RESP_W) begin : g_pkg_step
            assign w_next = misr_next(r_sig, i_y, POLY);
        end else begin : g_generic_step
            assign w_next = ({r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0)) ^ i_y;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_load) begin
            r_sig <= i_seed;
        end else if (i_en) begin
            r_sig <= w_next;
        end
    end

    assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/fsm_resp_misr.sv
`default_nettype none
// ============================================================================
// Module      : fsm_resp_misr
// Description : Windowed response compactor: folds controller outputs into a
//               MISR and scores the signature against a golden value.
//               FSM_RESP_MISR_EVT_CNT_EN adds the y17 activity counter.
// Revision    : 1.0  initial release
// ============================================================================
module fsm_resp_misr
    import fsm_resp_pkg::*;
#(
    parameter int               WIDTH = RESP_W,
    parameter int               WIN_W = 16,
    parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             y_vld,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [WIDTH-1:0] sig,
    output logic [WIN_W-1:0] cyc_cnt
`ifdef FSM_RESP_MISR_EVT_CNT_EN
    ,
    output logic [7:0]       evt_cnt
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_en;
    logic [WIN_W-1:0] r_cnt;
    logic [WIN_W-1:0] r_len;
    logic [WIN_W-1:0] w_len_m1;
    logic             r_match;
    logic             w_sig_eq;

    assign w_len_m1 = r_len - {{(WIN_W-1){1'b0}}, 1'b1};
    assign w_sig_eq = (sig == golden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (win_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (y_vld) begin
                    w_en = 1'b1;
                    if (r_cnt == w_len_m1) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_len   <= '0;
            r_match <= 1'b0;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_len   <= win_len;
            r_match <= 1'b0;
        end else begin
            if (w_en) begin
                r_cnt <= r_cnt + {{(WIN_W-1){1'b0}}, 1'b1};
            end
            if (r_state == ST_DONE) begin
                r_match <= w_sig_eq;
            end
        end
    end

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_seed (SEED),
        .i_en   (w_en),
        .i_y    (y),
        .o_sig  (sig)
    );

`ifdef FSM_RESP_MISR_EVT_CNT_EN
    logic [7:0] r_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt <= '0;
        end else if (w_load) begin
            r_evt <= '0;
        end else if (w_en && y[16] && (r_evt != 8'hFF)) begin
            r_evt <= r_evt + 8'd1;
        end
    end

    assign evt_cnt = r_evt;
`endif

    // Live compare during DONE so match is valid alongside the done pulse
    assign match   = (r_state == ST_DONE) ? w_sig_eq : r_match;
    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign cyc_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/fsm_resp_misr.md
# fsm_resp_misr

Downstream response compactor for the locked controller benchmarks. It samples the controller's 22 output lines (y1..y22, packed y[21:0] with y1 at bit 0) over a programmable window and folds them into a 22-bit multiple-input signature register (MISR). It compares the result against a supplied golden signature, so key-correctness and Trojan-trigger experiments can be scored in hardware without dumping every cycle.

## Interface
Parameters:
- WIDTH, 22, response width; equals the controller output count.
- WIN_W, 16, width of the window length and cycle counter.
- POLY, 22'h200001, feedback mask; bit i set means the MSB feeds back into bit i (x^22+x^21+1).
- SEED, 22'h000000, signature value loaded at start.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle request to begin a window; honoured only in IDLE.
- win_len, input, WIN_W, number of valid samples to compact; sampled when start is accepted.
- y_vld, input, 1, current y sample is valid.
- y, input, WIDTH, controller outputs.
- golden, input, WIDTH, expected signature; sampled in DONE.
- busy, output, 1, high in RUN.
- done, output, 1, one-cycle pulse at window end.
- match, output, 1, sig==golden; registered at done and held until the next start.
- sig, output, WIDTH, current signature.
- cyc_cnt, output, WIN_W, samples absorbed in the current or last window.
- evt_cnt, output, 8, saturating count of cycles with y[16] (y17) high during RUN; present only with the macro.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - sig<=SEED, cyc_cnt<=0, match<=0, len_q<=win_len, evt_cnt<=0.
  - Next state is RUN, or DONE if win_len==0.
- RUN, y_vld=1:
  - sig <= ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0)) ^ y.
  - cyc_cnt<=cyc_cnt+1.
  - If cyc_cnt==len_q-1, go to DONE.
- RUN, y_vld=0: sig and cyc_cnt hold.
- RUN, start=1: ignored. No restart mid-window.
- DONE: done=1, match<=(sig==golden); next state IDLE. sig and cyc_cnt hold until the next accepted start.
- Arithmetic: cyc_cnt is modulo 2^WIN_W but never wraps, because the window terminates at len_q. len_q=2^WIN_W-1 is legal.
- Controller outputs settle after its falling-edge state update. y is sampled at the following rising edge and is combinationally stable by then.

## Timing
- Reset values: state=IDLE, sig=0, cyc_cnt=0, busy=0, done=0, match=0, evt_cnt=0.
- Latency: done asserts on the cycle after the edge that absorbs the last valid sample. match is valid in the same cycle as done.
- Minimum window: win_len=0 gives start→DONE→IDLE, with done one cycle after start and sig=SEED.
- busy falls on the same edge that enters DONE.
- Reset mid-RUN: immediate return to IDLE. No done pulse; the partial signature is discarded (sig=0).
- start in the DONE cycle is ignored. A new window starts no earlier than the cycle after done.

## Configuration
- FSM_RESP_MISR_EVT_CNT_EN defined:
  - evt_cnt counts RUN cycles with y_vld&y[16], saturating at 8'hFF and cleared on start.
  - It exposes the payload-output activity of a Trojan-triggered controller.
- FSM_RESP_MISR_EVT_CNT_EN undefined: the evt_cnt port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package fsm_resp_pkg:
  - state enum {IDLE, RUN, DONE}.
  - RESP_W=22.
  - Default POLY constant.
  - misr_next(sig,y,poly) function.
- One natural sub-module, misr_core: the WIDTH-bit register with load/enable, instantiated by the control FSM.

## Test plan
- Reset: rst_n low mid-RUN, then high → sig=0, busy=0, done=0, match=0, no done pulse.
- win_len=1, y=22'h000001 → sig=22'h000001, cyc_cnt=1, done one cycle after the sample edge.
- win_len=2, y=22'h200000 then 22'h000000, golden=22'h200001 → sig=22'h200001, match=1. With golden=22'h000000 → match=0.
- win_len=3 with y_vld pattern 1,0,0,1,1 → exactly 3 samples absorbed, cyc_cnt=3, done on the fifth cycle +1. A start pulse during RUN has no effect.
- win_len=0 → done one cycle after start, sig=SEED, cyc_cnt=0.
- Macro on, win_len=300, y[16]=1 every valid cycle → evt_cnt saturates at 8'hFF. Macro off → the port is absent and the design elaborates cleanly.
